pwm_mask_sync: RTL and testbench

PWM_MASK_SYNC -- requirements
Module: pwm_mask_sync

---
 rtl/pwm_mask_pkg.sv | 15 +
 rtl/pwm_sync_divider.sv | 34 +++
 rtl/pwm_mask_sync.sv | 143 ++++++++++++++
 tb/tb_pwm_mask_sync.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_mask_pkg.sv
// Shared definitions for the PWM mask synchroniser: update-mode encodings and
// default sizing constants.
package pwm_mask_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int DIV_W_DEF = 8;

   typedef enum logic [1:0] {
      MODE_IMMEDIATE = 2'd0,
      MODE_SYNC      = 2'd1,
      MODE_DECIM     = 2'd2,
      MODE_FREEZE    = 2'd3
   } mode_e;

endpackage

// File: rtl/pwm_sync_divider.sv
// Sync-event decimator: hit fires on a tick when the down-counter sits at zero,
// and the counter reloads from div at that moment.
module pwm_sync_divider
   import pwm_mask_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             tick,
   input  logic [DIV_W-1:0] div,
   output logic             hit
);

   logic [DIV_W-1:0] divcnt;
   logic             at_zero;

   assign at_zero = (divcnt == '0);
   assign hit     = ce & tick & at_zero;

   // div is only sampled at reload, so a new ratio applies from the next period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divcnt <= '0;
      end else if (ce && tick) begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // pre-edge values, independent of statement order.
         if (at_zero) divcnt <= div;
         else         divcnt <= divcnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/pwm_mask_sync.sv
// Double-buffered PWM output mask with selectable update timing (immediate,
// carrier-synchronised, decimated, frozen) and a sticky fault trip.
module pwm_mask_sync
   import pwm_mask_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] mask_in,
   input  logic             mask_wr,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic             intmask,
   input  logic             trip,
   input  logic             trip_clr,
   output logic [WIDTH-1:0] mask_out,
   output logic             pending,
   output logic             update_pulse,
   output logic             tripped
);

   mode_e            cur_mode;
   logic [WIDTH-1:0] shadow;
   logic             init_done;
   logic             decim_hit;
   logic             sync_evt;
   logic             blocked;

   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] mask_d;
   logic             pending_d;
   logic             pulse_d;
   logic             tripped_d;
   logic             init_d;

   assign cur_mode = mode_e'(mode);

   pwm_sync_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .tick (intmask),
      .div  (div),
      .hit  (decim_hit)
   );

   assign sync_evt = (cur_mode == MODE_SYNC) ? intmask : decim_hit;
   assign blocked  = tripped | trip;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      shadow_d  = shadow;
      mask_d    = mask_out;
      pending_d = pending;
      pulse_d   = 1'b0;
      tripped_d = tripped;
      init_d    = init_done;

      if (ce) begin
         if (!init_done) begin
            // First enabled cycle after reset seeds both registers silently.
            init_d = 1'b1;
            if (!blocked) begin
               shadow_d = mask_in;
               mask_d   = mask_in;
            end
         end else if (blocked) begin
            if (mask_wr) begin
               shadow_d  = mask_in;
               pending_d = 1'b1;
            end
         end else begin
            case (cur_mode)
               MODE_IMMEDIATE: begin
                  if (mask_wr) begin
                     shadow_d  = mask_in;
                     mask_d    = mask_in;
                     pending_d = 1'b0;
                     pulse_d   = 1'b1;
                  end else if (pending) begin
                     mask_d    = shadow;
                     pending_d = 1'b0;
                     pulse_d   = 1'b1;
                  end
               end
               MODE_SYNC, MODE_DECIM: begin
                  // A write coinciding with an update lands behind it: the old
                  // shadow goes out and the new value stays pending.
                  if (sync_evt && pending) begin
                     mask_d    = shadow;
                     pulse_d   = 1'b1;
                     pending_d = mask_wr;
                  end else if (mask_wr) begin
                     pending_d = 1'b1;
                  end
                  if (mask_wr) shadow_d = mask_in;
               end
               default: begin
                  if (mask_wr) begin
                     shadow_d  = mask_in;
                     pending_d = 1'b1;
                  end
               end
            endcase
         end
      end

      // Trip handling ignores ce; trip beats trip_clr.
      if (trip) begin
         mask_d    = '0;
         tripped_d = 1'b1;
         pulse_d   = 1'b0;
      end else if (trip_clr && tripped) begin
         tripped_d = 1'b0;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow       <= '0;
         mask_out     <= '0;
         pending      <= 1'b0;
         update_pulse <= 1'b0;
         tripped      <= 1'b0;
         init_done    <= 1'b0;
      end else begin
         shadow       <= shadow_d;
         mask_out     <= mask_d;
         pending      <= pending_d;
         update_pulse <= pulse_d;
         tripped      <= tripped_d;
         init_done    <= init_d;
      end
   end

endmodule

// File: tb/tb_pwm_mask_sync.sv
// Scoreboard bench for pwm_mask_sync: stimulus pushes the expected outputs from a
// behavioural model; a monitor pops and compares after every clock edge.
module tb_pwm_mask_sync;

   localparam int W  = 32;
   localparam int DW = 8;

   typedef struct {
      logic          ce;
      logic          wr;
      logic [W-1:0]  mask_in;
      logic [1:0]    mode;
      logic [DW-1:0] div;
      logic          intmask;
      logic          trip;
      logic          trip_clr;
   } stim_t;

   typedef logic [W+2:0] obs_t;   // {mask_out, pending, update_pulse, tripped}

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [W-1:0]  mask_in;
   logic          mask_wr;
   logic [1:0]    mode;
   logic [DW-1:0] div;
   logic          intmask;
   logic          trip;
   logic          trip_clr;
   logic [W-1:0]  mask_out;
   logic          pending;
   logic          update_pulse;
   logic          tripped;

   pwm_mask_sync #(.WIDTH(W), .DIV_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .mask_in      (mask_in),
      .mask_wr      (mask_wr),
      .mode         (mode),
      .div          (div),
      .intmask      (intmask),
      .trip         (trip),
      .trip_clr     (trip_clr),
      .mask_out     (mask_out),
      .pending      (pending),
      .update_pulse (update_pulse),
      .tripped      (tripped)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_bad = 0;
   obs_t   exp_q[$];
   string  tag = "reset";
   logic [1:0]    cur_mode = 2'd1;
   logic [DW-1:0] cur_div  = '0;

   // Reference model state
   logic [W-1:0] m_mask, m_shadow;
   logic         m_pending, m_tripped, m_loaded;
   int           m_skip;   // sync events still to skip before the next DECIM update

   task automatic check(input string name, input obs_t act, input obs_t expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got mask=%h pend=%b pulse=%b trip=%b, want mask=%h pend=%b pulse=%b trip=%b",
                  name, act[W+2:3], act[2], act[1], act[0], expv[W+2:3], expv[2], expv[1], expv[0]);
      end
   endtask

   function automatic obs_t dut_obs();
      return {mask_out, pending, update_pulse, tripped};
   endfunction

   task automatic model_reset();
      m_mask = '0; m_shadow = '0; m_pending = 1'b0; m_tripped = 1'b0;
      m_loaded = 1'b0; m_skip = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input stim_t s);
      logic         pulse = 1'b0;
      logic         was_pending = m_pending;
      logic [W-1:0] old_shadow = m_shadow;
      logic         blk = m_tripped || s.trip;
      logic         evt;
      evt = (s.mode == 2'd1) ? s.intmask : (s.intmask && m_skip == 0);
      if (s.ce) begin
         if (!m_loaded) begin
            m_loaded = 1'b1;
            if (!blk) begin m_shadow = s.mask_in; m_mask = s.mask_in; end
         end else begin
            if (s.wr) begin m_shadow = s.mask_in; m_pending = 1'b1; end
            if (!blk) begin
               if (s.mode == 2'd0 && m_pending) begin
                  m_mask = m_shadow; m_pending = 1'b0; pulse = 1'b1;
               end else if ((s.mode == 2'd1 || s.mode == 2'd2) && evt && was_pending) begin
                  m_mask = old_shadow; m_pending = s.wr; pulse = 1'b1;
               end
            end
         end
         if (s.intmask) m_skip = (m_skip == 0) ? int'(s.div) : m_skip - 1;
      end
      if (s.trip) begin
         m_mask = '0; m_tripped = 1'b1; pulse = 1'b0;
      end else if (s.trip_clr && m_tripped) begin
         m_tripped = 1'b0; m_pending = 1'b1;
      end
      exp_q.push_back({m_mask, m_pending, pulse, m_tripped});
   endtask

   task automatic go(input logic c, input logic w, input logic [W-1:0] m,
                     input logic im, input logic tr, input logic tc);
      stim_t s;
      @(negedge clk);
      s.ce = c; s.wr = w; s.mask_in = m; s.mode = cur_mode; s.div = cur_div;
      s.intmask = im; s.trip = tr; s.trip_clr = tc;
      ce = c; mask_wr = w; mask_in = m; mode = cur_mode; div = cur_div;
      intmask = im; trip = tr; trip_clr = tc;
      model_step(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) go(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      ce = 1'b0; mask_wr = 1'b0; intmask = 1'b0; trip = 1'b0; trip_clr = 1'b0;
      #1;
      check("async_reset", dut_obs(), '0);
      model_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         check(tag, dut_obs(), e);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ce = 1'b0; mask_in = '0; mask_wr = 1'b0; mode = 2'd1; div = '0;
      intmask = 1'b0; trip = 1'b0; trip_clr = 1'b0;
      model_reset();
      #1;
      check("reset_state", dut_obs(), '0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      tag = "init_load";
      go(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
      idle(1);

      tag = "sync_update";
      go(1'b1, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
      idle(5);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(2);

      tag = "sync_wr_collide";
      go(1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
      idle(1);
      go(1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
      idle(2);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(1);

      tag = "decim_div2";
      cur_mode = 2'd2; cur_div = 8'd2;
      go(1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
      for (int p = 1; p <= 6; p++) begin
         go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
         if (p == 1) go(1'b1, 1'b1, 32'hBEEF_0004, 1'b0, 1'b0, 1'b0);
         else        idle(1);
      end

      tag = "trip_ce0";
      cur_mode = 2'd1; cur_div = '0;
      go(1'b1, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
      go(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      go(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      go(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b1);
      idle(3);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(1);

      tag = "trip_wins_then_immediate";
      go(1'b1, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
      go(1'b1, 1'b0, $urandom, 1'b0, 1'b1, 1'b1);
      cur_mode = 2'd0;
      go(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b1);
      idle(2);
      go(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
      idle(1);

      tag = "freeze_then_sync";
      cur_mode = 2'd3;
      go(1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(2);
      cur_mode = 2'd1;
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(1);

      tag = "reset_mid_pending";
      go(1'b1, 1'b1, 32'h7777_0000, 1'b0, 1'b0, 1'b0);
      async_reset();
      go(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      go(1'b1, 1'b0, 32'h0000_3C3C, 1'b0, 1'b0, 1'b0);
      go(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      idle(1);

      tag = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) cur_div  = DW'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) async_reset();
         go($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 14) == 0);
      end

      @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
